// File: rtl/ppu_sprite_eval.sv
// ppu_sprite_eval: per-scanline OAM scan for the first NUM_SLOTS sprites, pattern fetch,
// and one-hot loading of the sprite pixel generators over a shared bus.
module ppu_sprite_eval #(
   parameter int NUM_SLOTS   = 8,
   parameter int OAM_ENTRIES = 64
) (
   input  logic                 clk_25mhz,
   input  logic                 rst,
   input  logic                 start,
   input  logic [7:0]           scanline,
   input  logic                 sprite_size,
   input  logic                 pattern_base,
   output logic [7:0]           oam_addr,
   input  logic [7:0]           oam_data,
   output logic                 vram_rd,
   output logic [12:0]          vram_addr,
   input  logic [7:0]           vram_data,
   output logic                 busy,
   output logic                 done,
   output logic                 sprite_overflow,
   output logic                 sprite0_on_line,
   output logic [NUM_SLOTS-1:0] load_slot,
   output logic [7:0]           spr_xpos,
   output logic [7:0]           spr_attr,
   output logic [7:0]           spr_line0,
   output logic [7:0]           spr_line1
);
   localparam int CW = $clog2(NUM_SLOTS + 1);
   localparam int IW = $clog2(NUM_SLOTS);
   localparam int NW = $clog2(OAM_ENTRIES);

   typedef enum logic [2:0] {IDLE, SCAN_Y, SCAN_CHK, SCAN_ATTR, FETCH_LO, FETCH_HI, LOAD, DONE} state_t;
   state_t state, next;

   logic [NW-1:0] n;
   logic [1:0]    k;
   logic [CW-1:0] cnt;
   logic [IW-1:0] i;
   logic [7:0]    line_q, lo_q, oam_addr_q;
   logic          size_q, pb_q;
   logic [12:0]   vram_addr_q;
   logic [7:0]    tile_b [NUM_SLOTS];
   logic [7:0]    attr_b [NUM_SLOTS];
   logic [7:0]    x_b    [NUM_SLOTS];
   logic [3:0]    dy_b   [NUM_SLOTS];

   logic [7:0]  delta, tile, attr;
   logic [3:0]  dy, row;
   logic        hit, full, last_n, last_i, filled, next_filled, plane, ld;
   logic [12:0] fetch_addr;

   // delta wraps mod 256, so sprites just above line 0 never falsely hit
   assign delta       = line_q - oam_data;
   assign hit         = (delta < (size_q ? 8'd16 : 8'd8)) && (oam_data < 8'hF0);
   assign full        = cnt == CW'(NUM_SLOTS);
   assign last_n      = n == NW'(OAM_ENTRIES - 1);
   assign last_i      = i == IW'(NUM_SLOTS - 1);
   assign filled      = CW'(i) < cnt;
   assign next_filled = CW'(i) + CW'(1) < cnt;
   assign tile        = tile_b[i];
   assign attr        = attr_b[i];
   assign dy          = dy_b[i];
   assign row         = attr[7] ? (size_q ? 4'd15 : 4'd7) - dy : dy;
   assign plane       = state == FETCH_HI;
   assign fetch_addr  = size_q ? {tile[0], tile[7:1], row[3], plane, row[2:0]}
                               : {pb_q, tile, plane, row[2:0]};

   always_ff @(posedge clk_25mhz)
      state <= rst ? IDLE : next;

   always_comb begin
      next = state;
      case (state)
         IDLE:      next = start ? SCAN_Y : IDLE;
         SCAN_Y:    next = SCAN_CHK;
         SCAN_CHK:  next = (hit && !full) ? SCAN_ATTR
                         : (hit || last_n) ? (cnt != '0 ? FETCH_LO : LOAD) : SCAN_Y;
         SCAN_ATTR: next = k != 2'd2 ? SCAN_ATTR : last_n ? FETCH_LO : SCAN_Y;
         FETCH_LO:  next = FETCH_HI;
         FETCH_HI:  next = LOAD;
         LOAD:      next = last_i ? DONE : next_filled ? FETCH_LO : LOAD;
         default:   next = IDLE;
      endcase
   end

   // OAM reads are pipelined: Y at SCAN_Y, then tile/attr/X addresses on the following cycles
   always_comb begin
      ld        = state == LOAD;
      busy      = state inside {SCAN_Y, SCAN_CHK, SCAN_ATTR, FETCH_LO, FETCH_HI, LOAD};
      done      = state == DONE;
      vram_rd   = state inside {FETCH_LO, FETCH_HI};
      load_slot = ld ? NUM_SLOTS'(1) << i : '0;
      spr_xpos  = ld ? (filled ? x_b[i] : 8'hFF) : 8'h00;
      spr_attr  = ld && filled ? attr : 8'h00;
      spr_line0 = ld && filled ? lo_q : 8'h00;
      spr_line1 = ld && filled ? vram_data : 8'h00;
      oam_addr  = state == SCAN_Y ? 8'({n, 2'b00})
                : state == SCAN_CHK ? 8'({n, 2'b01})
                : (state == SCAN_ATTR && k != 2'd2) ? 8'({n, 2'b10 | k}) : oam_addr_q;
      vram_addr = vram_rd ? fetch_addr : vram_addr_q;
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         n               <= '0;
         k               <= '0;
         cnt             <= '0;
         i               <= '0;
         line_q          <= '0;
         size_q          <= 1'b0;
         pb_q            <= 1'b0;
         lo_q            <= '0;
         oam_addr_q      <= '0;
         vram_addr_q     <= '0;
         sprite_overflow <= 1'b0;
         sprite0_on_line <= 1'b0;
      end else begin
         oam_addr_q  <= oam_addr;
         vram_addr_q <= vram_addr;
         case (state)
            IDLE: if (start) begin
               line_q          <= scanline;
               size_q          <= sprite_size;
               pb_q            <= pattern_base;
               cnt             <= '0;
               n               <= '0;
               sprite_overflow <= 1'b0;
               sprite0_on_line <= 1'b0;
            end
            SCAN_CHK: begin
               k <= '0;
               i <= '0;
               if (hit && full) sprite_overflow <= 1'b1;
               if (hit && !full) begin
                  dy_b[cnt[IW-1:0]] <= delta[3:0];
                  if (n == '0) sprite0_on_line <= 1'b1;
               end else n <= n + 1'b1;
            end
            SCAN_ATTR: begin
               k <= k + 1'b1;
               if (k == 2'd0) tile_b[cnt[IW-1:0]] <= oam_data;
               if (k == 2'd1) attr_b[cnt[IW-1:0]] <= oam_data;
               if (k == 2'd2) begin
                  x_b[cnt[IW-1:0]] <= oam_data;
                  cnt              <= cnt + 1'b1;
                  n                <= n + 1'b1;
               end
            end
            FETCH_HI: lo_q <= vram_data;
            LOAD:     i <= i + 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: doc/ppu_sprite_eval.md
Name: ppu_sprite_eval

Overview:
Per-scanline sprite evaluation and pattern-fetch stage. It sits directly upstream of the bank of sprite pixel generators. On each start pulse it scans OAM for sprites that intersect the next scanline and keeps the first NUM_SLOTS hits. It then fetches both pattern planes for each hit and loads the generators one at a time over a shared bus, using one-hot load strobes.

Parameters:
NUM_SLOTS, 8, number of sprite generator slots loaded per line
OAM_ENTRIES, 64, sprites in OAM (4 bytes each: Y, tile, attr, X)

Ports:
clk_25mhz  in  1  pixel clock; the only clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse at the start of the evaluation window
scanline  in  8  line being prepared (0..239)
sprite_size  in  1  0=8x8, 1=8x16
pattern_base  in  1  pattern table select, 8x8 mode only
oam_addr  out  8  OAM byte address
oam_data  in  8  OAM read data, valid 1 cycle after oam_addr
vram_rd  out  1  pattern read strobe
vram_addr  out  13  pattern address
vram_data  in  8  pattern data, valid 1 cycle after vram_rd
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when all slots are loaded
sprite_overflow  out  1  more than NUM_SLOTS hits on the line; held until the next start
sprite0_on_line  out  1  OAM entry 0 is in slot 0; held until the next start
load_slot  out  NUM_SLOTS  one-hot load strobe to the generators
spr_xpos, spr_attr, spr_line0, spr_line1  out  8 each  shared load bus, valid while any load_slot bit is high

Behaviour:
- Single clock is clk_25mhz; rst is synchronous and active-high. Polarity and synchronicity are fixed.
- Reset: FSM goes to IDLE. All outputs are 0, and the slot count and flags are cleared. Reset during any state aborts the operation; no partial loads are issued afterwards.
- States: IDLE, SCAN_Y, SCAN_CHK, SCAN_ATTR (3 reads: tile, attr, X), FETCH_LO, FETCH_HI, LOAD, DONE.
- IDLE:
  - A start pulse latches scanline, sprite_size and pattern_base.
  - It clears the count, sprite_overflow and sprite0_on_line, sets entry n=0 and moves to SCAN_Y.
  - start is ignored while busy=1.
- Scan, miss case:
  - SCAN_Y drives oam_addr=4n. In SCAN_CHK, oam_data is the Y byte.
  - delta = (scanline - Y) mod 256. height = 8 or 16.
  - Hit if delta < height and Y < 0xF0. Y >= 0xF0 never hits.
  - A miss costs 2 cycles and moves to n+1.
- Scan, hit case:
  - When count < NUM_SLOTS, read 4n+1, 4n+2 and 4n+3 back-to-back (pipelined, 3 cycles) into slot buffer[count]. Also store delta.
  - count increments. If n==0, set sprite0_on_line.
  - A hit costs 5 cycles.
- Scan, overflow: a hit with count == NUM_SLOTS sets sprite_overflow and ends the scan immediately.
- Scan end: the scan ends after entry OAM_ENTRIES-1 or on overflow, then moves to the fetch phase with slot i=0.
- Fetch row:
  - row = attr[7] ? (height-1-delta) : delta. Vertical flip is applied here; horizontal flip is the generator's job.
- Fetch address:
  - 8x8 mode: vram_addr = {pattern_base, tile[7:0], plane, row[2:0]}.
  - 8x16 mode: vram_addr = {tile[0], tile[7:1], row[3], plane, row[2:0]}.
  - plane is 0 in FETCH_LO and 1 in FETCH_HI. vram_rd is high only in these two states.
- Fetch sequence for filled slots (i < count):
  - FETCH_LO, then FETCH_HI (capturing lo), then LOAD (capturing hi).
  - LOAD asserts load_slot = (1<<i) for exactly 1 cycle, with spr_xpos=X, spr_attr=attr, spr_line0=lo, spr_line1=hi.
  - Each filled slot takes 3 cycles.
- Fetch sequence for empty slots (i >= count):
  - One LOAD cycle with spr_xpos=0xFF and attr/line0/line1=0x00; the generator treats 0xFF as empty.
  - No VRAM reads are issued.
- Slot order: slots always load in ascending index. Exactly NUM_SLOTS load strobes are issued per start.
- DONE: done=1 for 1 cycle, then back to IDLE. busy drops in the same cycle done is high.
- Latency:
  - Worst case is 64 entries × 2 + 8 × 3 extra for hits + 8 × 3 for fetch + 2 = 178 cycles.
  - The system must issue start at least 178 cycles before the line's first pixel.
- When idle, oam_addr and vram_addr hold their last value.

Test Plan:
- OAM all Y=0xFF, start at scanline=10 → 128 scan cycles with no VRAM reads; 8 loads with spr_xpos=0xFF; done; overflow=0; sprite0_on_line=0.
- Entry 0: Y=8, tile=0x12, attr=0x01, X=40. scanline=11, 8x8, pattern_base=0 → vram_addr 0x0123 then 0x012B. Slot 0 loads X=40, attr=0x01, line0/line1 = data returned. Slots 1-7 load empty. sprite0_on_line=1.
- Same sprite with attr=0x80 (vertical flip) → row=4, vram_addr 0x0124 / 0x012C.
- 8x16 mode, tile=0x13, Y=0, scanline=12 → row=12, vram_addr {1,0x09,1,0,100} = 0x1134, then 0x113C.
- Ten sprites with Y=20, scanline=22 → entries 0..7 fill slots 0..7; the scan stops at entry 8 with sprite_overflow=1; eight filled loads are issued.
- Assert rst in FETCH_HI → next cycle busy=0 and load_slot=0; a following start produces a complete, correct sequence. A start pulse while busy changes nothing.
